// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared sizes, types and write-enable helpers for the register file.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int NUM_REGS         = 32;
    localparam int ADDR_W           = 5;
    localparam int DEFAULT_ZERO_REG = 31;

    typedef logic [ADDR_W-1:0]   reg_idx_t;
    typedef logic [NUM_REGS-1:0] wr_onehot_t;

    // Popcount > 1: clearing the lowest set bit leaves something behind.
    function automatic logic multi_hot(input wr_onehot_t v);
        return (v & (v - wr_onehot_t'(1))) != '0;
    endfunction

    function automatic reg_idx_t onehot_to_idx(input wr_onehot_t v);
        reg_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (v[i]) begin
                idx = reg_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux32to1.sv
// ============================================================================
// Module  : mux32to1
// Brief   : 32-input WIDTH-bit selector, one per register-file read port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mux32to1
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data_i [NUM_REGS],
    input  reg_idx_t         sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = data_i[sel_i];

endmodule

`default_nettype wire

// File: rtl/regfile_read_side.sv
// ============================================================================
// Module  : regfile_read_side
// Brief   : 32-entry register storage with two registered read ports and a
//           sticky non-one-hot write-enable flag. Optional write-through
//           forwarding is compiled in with `define REGFILE_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_read_side
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic                onehot_err
);

    logic             wr_multi;
    logic             wr_single;
    logic [WIDTH-1:0] reg_file [NUM_REGS];
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [WIDTH-1:0] rd_sel_a;
    logic [WIDTH-1:0] rd_sel_b;

    logic             rd_valid_q,   rd_valid_d;
    logic [WIDTH-1:0] rd_data_a_q,  rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q,  rd_data_b_d;
    logic             onehot_err_q, onehot_err_d;

    assign wr_multi  = multi_hot(wr_en);
    assign wr_single = (wr_en != '0) && !wr_multi;

    // The zero register has no storage at all, so a legal write to it is
    // simply dropped and it can never read back non-zero.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            if (i == ZERO_REG) begin : g_zero
                assign reg_file[i] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] reg_q;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        reg_q <= '0;
                    end else if (wr_single && wr_en[i]) begin
                        reg_q <= wr_data;
                    end
                end

                assign reg_file[i] = reg_q;
            end
        end
    endgenerate

    mux32to1 #(.WIDTH(WIDTH)) u_mux_a (
        .data_i (reg_file),
        .sel_i  (rd_addr_a),
        .y_o    (mux_a)
    );

    mux32to1 #(.WIDTH(WIDTH)) u_mux_b (
        .data_i (reg_file),
        .sel_i  (rd_addr_b),
        .y_o    (mux_b)
    );

`ifdef REGFILE_BYPASS_EN
    reg_idx_t wr_idx;
    logic     fwd_a;
    logic     fwd_b;

    // Only a single, non-zero-register write is forwarded; a multi-hot
    // write never lands, so it must never be seen on a read port either.
    assign wr_idx   = onehot_to_idx(wr_en);
    assign fwd_a    = wr_single && (wr_idx == rd_addr_a)
                      && (rd_addr_a != reg_idx_t'(ZERO_REG));
    assign fwd_b    = wr_single && (wr_idx == rd_addr_b)
                      && (rd_addr_b != reg_idx_t'(ZERO_REG));
    assign rd_sel_a = fwd_a ? wr_data : mux_a;
    assign rd_sel_b = fwd_b ? wr_data : mux_b;
`else
    assign rd_sel_a = mux_a;
    assign rd_sel_b = mux_b;
`endif

    always_comb begin
        rd_valid_d   = rd_req;
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        onehot_err_d = onehot_err_q | wr_multi;
        if (rd_req) begin
            rd_data_a_d = rd_sel_a;
            rd_data_b_d = rd_sel_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q   <= 1'b0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            onehot_err_q <= 1'b0;
        end else begin
            rd_valid_q   <= rd_valid_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign onehot_err = onehot_err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_side.sv
// ============================================================================
// Module  : tb_regfile_read_side
// Brief   : Directed self-checking bench for regfile_read_side.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_read_side;

    logic        clk;
    logic        reset;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_valid;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        onehot_err;

    int vectors;
    int miscompares;

    regfile_read_side #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_valid   (rd_valid),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .onehot_err (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] en, input logic [63:0] data);
        wr_en   = en;
        wr_data = data;
        tick();
        wr_en   = '0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        rd_req    = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        tick();
        rd_req    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || onehot_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b a=%h b=%h err=%b, required 0/0/0/0",
                     rd_valid, rd_data_a, rd_data_b, onehot_err);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            vectors++;
            if (rd_valid !== 1'b1 || rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_read_%0d: valid=%b a=%h b=%h, required 1/0/0", i, rd_valid, rd_data_a, rd_data_b);
            end
            tick();
            vectors++;
            if (rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read_pulse_%0d: valid=%b, required 0", i, rd_valid);
            end
        end
        vectors++;
        if (onehot_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: err=%b, required 0", onehot_err);
        end
    endtask

    task automatic test_write_read();
        do_write(32'h0000_0020, 64'hDEAD_BEEF_0000_0005);
        do_read(5'd5, 5'd5);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data_a !== 64'hDEAD_BEEF_0000_0005 || rd_data_b !== 64'hDEAD_BEEF_0000_0005) begin
            miscompares++;
            $display("FAIL write_read: valid=%b a=%h b=%h, required 1/deadbeef00000005 on both", rd_valid, rd_data_a, rd_data_b);
        end
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd1;
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'hDEAD_BEEF_0000_0005 || rd_data_b !== 64'hDEAD_BEEF_0000_0005) begin
            miscompares++;
            $display("FAIL idle_hold: valid=%b a=%h b=%h, required 0 with data held", rd_valid, rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_zero_reg();
        do_write(32'h8000_0000, 64'h1234);
        do_read(5'd31, 5'd5);
        vectors++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'hDEAD_BEEF_0000_0005 || onehot_err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_reg: a=%h b=%h err=%b, required 0/deadbeef00000005/0", rd_data_a, rd_data_b, onehot_err);
        end
    endtask

    task automatic test_same_edge();
        logic [63:0] exp9;
        do_write(32'h0000_0200, 64'h55);
        wr_en     = 32'h0000_0200;
        wr_data   = 64'hAA;
        rd_req    = 1'b1;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd5;
        tick();
        wr_en  = '0;
        rd_req = 1'b0;
`ifdef REGFILE_BYPASS_EN
        exp9 = 64'hAA;
`else
        exp9 = 64'h55;
`endif
        vectors++;
        if (rd_data_a !== exp9 || rd_data_b !== 64'hDEAD_BEEF_0000_0005) begin
            miscompares++;
            $display("FAIL same_edge: a=%h b=%h, required %h/deadbeef00000005", rd_data_a, rd_data_b, exp9);
        end
        do_read(5'd9, 5'd9);
        vectors++;
        if (rd_data_a !== 64'hAA || rd_data_b !== 64'hAA) begin
            miscompares++;
            $display("FAIL after_same_edge: a=%h b=%h, required aa/aa", rd_data_a, rd_data_b);
        end
        // Forwarding must never expose a write to the zero register.
        wr_en     = 32'h8000_0000;
        wr_data   = 64'hBEEF;
        rd_req    = 1'b1;
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd31;
        tick();
        wr_en  = '0;
        rd_req = 1'b0;
        vectors++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            miscompares++;
            $display("FAIL same_edge_zero: a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addr_a [3];
        logic [4:0]  addr_b [3];
        logic [63:0] exp_a  [3];
        logic [63:0] exp_b  [3];
        do_write(32'h0000_0002, 64'h11);
        do_write(32'h0000_0004, 64'h22);
        addr_a = '{5'd1, 5'd2, 5'd9};
        addr_b = '{5'd2, 5'd1, 5'd5};
        exp_a  = '{64'h11, 64'h22, 64'hAA};
        exp_b  = '{64'h22, 64'h11, 64'hDEAD_BEEF_0000_0005};
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr_a = addr_a[i];
            rd_addr_b = addr_b[i];
            tick();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data_a !== exp_a[i] || rd_data_b !== exp_b[i]) begin
                miscompares++;
                $display("FAIL back_to_back_%0d: valid=%b a=%h b=%h, required 1/%h/%h",
                         i, rd_valid, rd_data_a, rd_data_b, exp_a[i], exp_b[i]);
            end
        end
        rd_req = 1'b0;
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'hAA) begin
            miscompares++;
            $display("FAIL back_to_back_end: valid=%b a=%h, required 0/aa", rd_valid, rd_data_a);
        end
    endtask

    task automatic test_onehot_err();
        do_write(32'h0000_0008, 64'h3);
        do_write(32'h0000_0080, 64'h7);
        vectors++;
        if (onehot_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_before: err=%b, required 0", onehot_err);
        end
        do_write(32'h0000_0088, 64'hFFFF);
        vectors++;
        if (onehot_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: err=%b, required 1", onehot_err);
        end
        do_read(5'd3, 5'd7);
        vectors++;
        if (rd_data_a !== 64'h3 || rd_data_b !== 64'h7) begin
            miscompares++;
            $display("FAIL multi_hot_no_write: a=%h b=%h, required 3/7", rd_data_a, rd_data_b);
        end
        do_write(32'h0000_0010, 64'h44);
        tick();
        tick();
        vectors++;
        if (onehot_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, required 1", onehot_err);
        end
    endtask

    task automatic test_reset_mid_read();
        do_read(5'd9, 5'd5);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || onehot_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_read: valid=%b a=%h b=%h err=%b, required all 0",
                     rd_valid, rd_data_a, rd_data_b, onehot_err);
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_read(5'd9, 5'd5);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            miscompares++;
            $display("FAIL post_reset_9_5: valid=%b a=%h b=%h, required 1/0/0", rd_valid, rd_data_a, rd_data_b);
        end
        do_read(5'd3, 5'd7);
        vectors++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
            miscompares++;
            $display("FAIL post_reset_3_7: a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        wr_en       = '0;
        wr_data     = '0;
        rd_req      = 1'b0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;

        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_edge();
        test_back_to_back();
        test_onehot_err();
        test_reset_mid_read();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
